seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: none; datapath width fixed at 16 bits (package constant MULT_W = 16).
REQ-002 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-004 A  input  16  unsigned multiplicand, sampled only on accepted Load.
REQ-005 B  input  16  unsigned multiplier, sampled only on accepted Load.
REQ-006 Load  input  1  start request, level-sampled each posedge.
REQ-007 Hi  output  16  upper half of 32-bit product; working register while Busy.
REQ-008 Lo  output  16  lower half of 32-bit product; working register while Busy.
REQ-009 Done  output  1  level; high = Hi/Lo hold valid product of last accepted operands.
REQ-010 Busy  output  1  high from the edge after Load is accepted until the FIN edge.

Function
REQ-011 States SHALL be IDLE, CALC, FIN; encoding from the package enum.
REQ-012 IDLE: Load=1 at an edge SHALL capture M<=A, Lo<=B, Hi<=0, cnt<=0, Done<=0, Busy<=1, go to CALC; Load=0 holds all registers.
REQ-013 CALC, per edge: if Lo[0]=1, {c,s} = Hi+M (17-bit), else {c,s} = {0,Hi}; then {Hi,Lo} <= {c,s,Lo[15:1]}; cnt <= cnt+1.
REQ-014 CALC SHALL run exactly 16 iterations (cnt 0..15); the edge performing iteration 15 SHALL move to FIN.
REQ-015 FIN: next edge SHALL set Done<=1, Busy<=0, go to IDLE; Hi/Lo unchanged.
REQ-016 Latency: Load accepted at edge k -> Done high after edge k+17, Busy high after edges k+1..k+16.
REQ-017 Product SHALL equal A*B modulo 2^32 exactly; carry c SHALL never be discarded.
REQ-018 Load while Busy (CALC or FIN) SHALL be ignored; operands and result unaffected.
REQ-019 Done and Hi/Lo SHALL hold indefinitely in IDLE until next accepted Load; accepting Load clears Done on that same edge.
REQ-020 A/B changes while Busy SHALL not affect the result.

Reset
REQ-021 Reset=1 at an edge SHALL force state IDLE, Hi=0, Lo=0, M=0, cnt=0, Done=0, Busy=0, overriding Load and any in-flight operation.
REQ-022 Reset mid-CALC SHALL abandon the operation; first Load after Reset deasserts SHALL start a fresh 17-cycle operation.

Configuration
REQ-023 Macro MULT_ZERO_BYPASS_EN: when defined, accepted Load with A==0 or B==0 SHALL go straight to FIN with Hi=Lo=0 (Done high after edge k+2, Busy high only after edge k+1).
REQ-024 Without MULT_ZERO_BYPASS_EN, zero operands SHALL take the full 16 iterations (Done after edge k+17).

Structure
REQ-025 Package mult_pkg SHALL hold MULT_W, MULT_ITER=16, and the state enum {IDLE, CALC, FIN}.
REQ-026 The 16-bit add SHALL use one instance of the existing my16bitaddsub_gate in add mode (sub-select tied 0); no other sub-modules.

Verification
REQ-027 A=0x0003, B=0x0005, Load 1 cycle -> Done high after edge k+17, Hi=0x0000, Lo=0x000F.
REQ-028 A=0xFFFF, B=0xFFFF -> Hi=0xFFFE, Lo=0x0001; A=0x8000, B=0x0002 -> Hi=0x0001, Lo=0x0000.
REQ-029 A=0x1234, B=0x0000 -> Hi=Lo=0; Done after edge k+2 with MULT_ZERO_BYPASS_EN, after edge k+17 without.
REQ-030 Start 0x00FF*0x0101, pulse Load with A=0x0002,B=0x0002 at cycle 5 -> ignored; result Hi=0x0000, Lo=0xFFFF.
REQ-031 Start 0x1234*0x5678, Reset at cycle 8 -> next edge Hi=Lo=0, Done=0, Busy=0; then 0x1234*0x5678 -> Hi=0x0626, Lo=0x0060.
REQ-032 With Done=1 in IDLE, Load 0x0002*0x0003 -> Done cleared on accept edge, set again 17 edges later, Lo=0x0006.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_pkg;

   localparam int MULT_W    = 16;
   localparam int MULT_ITER = 16;
   localparam int CNT_W     = $clog2(MULT_ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/my16bitaddsub_gate.sv
// 16-bit ripple-carry adder/subtractor built from bit-level gates.
// sub_i=1 computes a_i - b_i (two's complement); cout_o is the raw carry out.
module my16bitaddsub_gate (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        sub_i,
   output logic [15:0] sum_o,
   output logic        cout_o
);

   logic [15:0] bx;
   logic [16:0] c;

   assign bx   = b_i ^ {16{sub_i}};
   assign c[0] = sub_i;

   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign sum_o[i] = a_i[i] ^ bx[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
   end

   assign cout_o = c[16];

endmodule

// File: rtl/seq_multiplier.sv
// 16x16 unsigned shift-add multiplier, one partial product per clock (17-cycle op).
// Optional MULT_ZERO_BYPASS_EN: zero operands skip the iterations and finish early.
module seq_multiplier
   import mult_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [MULT_W-1:0] A,
   input  logic [MULT_W-1:0] B,
   input  logic              Load,
   output logic [MULT_W-1:0] Hi,
   output logic [MULT_W-1:0] Lo,
   output logic              Done,
   output logic              Busy
);

   state_t            state_q, state_d;
   logic [MULT_W-1:0] hi_q, hi_d;
   logic [MULT_W-1:0] lo_q, lo_d;
   logic [MULT_W-1:0] m_q, m_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic [MULT_W-1:0] addend;
   logic [MULT_W-1:0] sum;
   logic              cout;

   // Adding zero when the multiplier bit is clear yields {0,Hi} with no extra mux.
   assign addend = lo_q[0] ? m_q : '0;

   my16bitaddsub_gate u_add (
      .a_i    (hi_q),
      .b_i    (addend),
      .sub_i  (1'b0),
      .sum_o  (sum),
      .cout_o (cout)
   );

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (Load) begin
               m_d     = A;
               lo_d    = B;
               hi_d    = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            {hi_d, lo_d} = {cout, sum, lo_q[MULT_W-1:1]};
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MULT_ITER - 1)) state_d = FIN;
`ifdef MULT_ZERO_BYPASS_EN
            // Operands are still intact on the first iteration; zero product is known.
            if (cnt_q == '0 && (m_q == '0 || lo_q == '0)) begin
               hi_d    = '0;
               lo_d    = '0;
               state_d = FIN;
            end
`endif
         end
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign Hi   = hi_q;
   assign Lo   = lo_q;
   assign Done = done_q;
   assign Busy = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: spec vectors, corner sequences, random ops vs a*b.
module tb_seq_multiplier;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] A, B;
   logic        Load;
   logic [15:0] Hi, Lo;
   logic        Done, Busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] hi;
      logic [15:0] lo;
   } vec_t;

   vec_t tbl[5];

   seq_multiplier dut (
      .Clk  (Clk),
      .Reset(Reset),
      .A    (A),
      .B    (B),
      .Load (Load),
      .Hi   (Hi),
      .Lo   (Lo),
      .Done (Done),
      .Busy (Busy)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef MULT_ZERO_BYPASS_EN
      if (a == 16'h0 || b == 16'h0) return 2;
`endif
      return 17;
   endfunction

   // Launch one multiply, count edges until Done, then check product and hold.
   // inject_at>0 pulses a Load (A=2,B=2) on that edge after acceptance.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input int inject_at, input string nm);
      int          n;
      bit          seen;
      int          busy_bad;
      logic [31:0] held;
      A = a; B = b; Load = 1'b1;
      tick();
      Load = 1'b0;
      A = 16'($urandom); B = 16'($urandom);
      chk({nm, " done@accept"}, 32'(Done), 32'd0);
      chk({nm, " busy@accept"}, 32'(Busy), 32'd1);
      n = 0; seen = 0; busy_bad = 0;
      while (!seen && n < 40) begin
         if (n + 1 == inject_at) begin
            A = 16'h0002; B = 16'h0002; Load = 1'b1;
         end
         tick();
         Load = 1'b0;
         n++;
         if (Done) seen = 1;
         else if (!Busy) busy_bad++;
      end
      chk({nm, " latency"}, 32'(n), 32'(exp_lat(a, b)));
      chk({nm, " busy gaps"}, 32'(busy_bad), 32'd0);
      chk({nm, " busy@done"}, 32'(Busy), 32'd0);
      chk({nm, " product"}, {Hi, Lo}, exp_p);
      held = {Hi, Lo};
      tick(); tick();
      chk({nm, " hold done"}, 32'(Done), 32'd1);
      chk({nm, " hold prod"}, {Hi, Lo}, held);
   endtask

   initial begin
      tbl[0] = '{a: 16'h0003, b: 16'h0005, hi: 16'h0000, lo: 16'h000F};
      tbl[1] = '{a: 16'hFFFF, b: 16'hFFFF, hi: 16'hFFFE, lo: 16'h0001};
      tbl[2] = '{a: 16'h8000, b: 16'h0002, hi: 16'h0001, lo: 16'h0000};
      tbl[3] = '{a: 16'h1234, b: 16'h0000, hi: 16'h0000, lo: 16'h0000};
      tbl[4] = '{a: 16'h0000, b: 16'hBEEF, hi: 16'h0000, lo: 16'h0000};

      Reset = 1'b1; Load = 1'b1; A = 16'hAAAA; B = 16'h5555;
      tick(); tick();
      Reset = 1'b0; Load = 1'b0;
      chk("reset hilo", {Hi, Lo}, 32'd0);
      chk("reset done", 32'(Done), 32'd0);
      chk("reset busy", 32'(Busy), 32'd0);
      tick();
      chk("idle hold", {15'd0, Busy, Hi, Lo}, 32'd0);

      foreach (tbl[i])
         run_op(tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, 0, $sformatf("vec%0d", i));

      // Load while busy must be ignored.
      run_op(16'h00FF, 16'h0101, 32'h0000FFFF, 5, "ignore load");

      // Reset mid-operation abandons it; a fresh op follows.
      A = 16'h1234; B = 16'h5678; Load = 1'b1;
      tick();
      Load = 1'b0;
      repeat (7) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("midreset hilo", {Hi, Lo}, 32'd0);
      chk("midreset done", 32'(Done), 32'd0);
      chk("midreset busy", 32'(Busy), 32'd0);
      run_op(16'h1234, 16'h5678, 32'h06260060, 0, "after reset");

      // Back-to-back from Done=1 clears Done on the accept edge.
      run_op(16'h0002, 16'h0003, 32'h00000006, 0, "reload");

      for (int r = 0; r < 20; r++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (r == 3) ra = 16'h0;
         if (r == 7) rb = 16'hFFFF;
         run_op(ra, rb, 32'(ra) * 32'(rb), 0, $sformatf("rand%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
